mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch (IF) requester and data-memory (MEM stage) requester. Sits between the IF stage / MEM stage of the 5-stage RV32I core and the memory. It sequences one outstanding memory transaction at a time, gives data accesses priority with a starvation guard for fetch, and discards fetch responses killed by taken branches or JALR redirects.

## Interface
- AW, 32, address width
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending (≥1)

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_rvalid or if_kill
- if_addr  in  AW  fetch address
- if_kill  in  1  cancel current/pending fetch (redirect)
- if_rvalid  out  1  one-cycle fetch completion pulse
- if_rdata  out  32  instruction, valid with if_rvalid
- d_req  in  1  data request; held with fields until d_rvalid
- d_we  in  1  1 = store
- d_be  in  4  byte enables (stores)
- d_addr  in  AW  data address
- d_wdata  in  32  store data
- d_rvalid  out  1  one-cycle data completion pulse (loads and stores)
- d_rdata  out  32  load data, valid with d_rvalid
- m_req  out  1  memory request; held until m_gnt
- m_we  out  1  memory write
- m_be  out  4  memory byte enables (4'b1111 for fetch and loads)
- m_addr  out  AW  memory address
- m_wdata  out  32  memory write data
- m_gnt  in  1  memory accepts request this cycle
- m_rvalid  in  1  memory response (read data or write ack), earliest cycle after m_gnt
- m_rdata  in  32  memory read data
- busy  out  1  transaction outstanding (state ≠ IDLE)

## Operation
- States: IDLE, REQ, WAIT. owner register ∈ {IF, D}.
- IDLE: arbitrate among d_req and (if_req && !if_kill). Winner latched into owner and m_* registers; go REQ. No request: stay IDLE.
- Priority: D wins, except when if_req pending and d_streak == MAX_D_STREAK, then IF wins.
- d_streak (width ≥ clog2(MAX_D_STREAK+1)): +1 on each D grant made while if_req high; cleared on IF grant or on any arbitration with if_req low; saturates at MAX_D_STREAK.
- REQ: m_req=1, m_* stable; on m_gnt go WAIT (m_req low next cycle).
- WAIT: on m_rvalid go IDLE; drive completion to owner that cycle.
- if_rvalid = m_rvalid && state==WAIT && owner==IF && !drop; if_rdata = m_rdata. d_rvalid/d_rdata likewise for owner==D (no drop). Combinational from m_rvalid.
- drop: set when if_kill asserted while owner==IF in REQ or WAIT; transaction still completes on the memory side, response suppressed; cleared on entry to IDLE.
- if_kill in IDLE masks if_req that cycle only.
- m_rvalid outside WAIT, m_gnt outside REQ: ignored.
- Stores complete on m_rvalid (write ack); d_rdata undefined for stores.

## Timing
- Reset (async, immediate): state IDLE, owner IF, drop 0, d_streak 0, m_req 0, m_we 0, m_be 0, m_addr 0, m_wdata 0, busy 0, if_rvalid 0, d_rvalid 0.
- Min latency with m_gnt immediate and m_rvalid one cycle after: req seen cycle 0 (IDLE) → m_req cycle 1 → m_rvalid/requester rvalid cycle 2. Throughput one transaction per 3 cycles min.
- Requester deasserts or changes request the cycle after its rvalid; arbitration occurs in the IDLE cycle following WAIT.
- m_gnt backpressure: REQ held N cycles adds N-1 cycles latency; m_* unchanged throughout.
- if_kill same cycle as m_rvalid for IF: response suppressed.
- Reset mid-transaction: abort immediately; late m_rvalid after reset ignored (state IDLE).

## Test plan
- Single fetch, if_addr=0x0000_0010, m_gnt immediate, m_rdata=0x0000_0093 next cycle -> m_req cycle 1, if_rvalid cycle 2 with if_rdata=0x0000_0093; busy 1 in cycles 1-2.
- if_req and d_req (store addr 0x100, wdata 0xDEAD_BEEF, be 4'b0011) same cycle -> store issued first (m_we=1, m_be=4'b0011), d_rvalid, then fetch issued in next IDLE arbitration.
- MAX_D_STREAK=2, d_req and if_req held continuously -> grant order D, D, IF, D, D, IF; d_streak returns to 0 after each IF grant.
- Fetch in WAIT, if_kill pulsed, then m_rvalid -> if_rvalid stays 0; next if_req at new addr 0x40 issues fresh transaction and completes normally.
- m_gnt held low 3 cycles during load -> m_req high 3+ cycles, m_addr/m_be stable, d_rvalid one cycle after grant-cycle-following m_rvalid; no second m_req.
- reset_n low during WAIT, m_rvalid arrives after release -> all outputs at reset values, no if_rvalid/d_rvalid pulse, next request served normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic          if_rvalid;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          m_req;
    logic          m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic          m_gnt;
    logic          m_rvalid;
    logic [31:0]   m_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  m_gnt, m_rvalid, m_rdata,
        output if_rvalid, if_rdata, d_rvalid, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output m_gnt, m_rvalid, m_rdata,
        input  if_rvalid, if_rdata, d_rvalid, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and data accesses; data has priority, fetch is protected by a streak limit.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t        r_state;
    logic          r_owner_d;
    logic          r_drop;
    logic [SW-1:0] r_d_streak;
    logic          r_m_req;
    logic          r_m_we;
    logic [3:0]    r_m_be;
    logic [AW-1:0] r_m_addr;
    logic [31:0]   r_m_wdata;

    logic w_if_cand, w_streak_full, w_grant_if, w_grant_d, w_done;

    // A fetch killed in the same IDLE cycle is not a candidate at all.
    assign w_if_cand     = bus.if_req && !bus.if_kill;
    assign w_streak_full = (r_d_streak == SW'(MAX_D_STREAK));
    assign w_grant_if    = w_if_cand && (!bus.d_req || w_streak_full);
    assign w_grant_d     = bus.d_req && !w_grant_if;
    assign w_done        = (r_state == S_WAIT) && bus.m_rvalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_owner_d  <= 1'b0;
            r_drop     <= 1'b0;
            r_d_streak <= '0;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_be     <= 4'b0000;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_if) begin
                        r_owner_d  <= 1'b0;
                        r_m_req    <= 1'b1;
                        r_m_we     <= 1'b0;
                        r_m_be     <= 4'b1111;
                        r_m_addr   <= bus.if_addr;
                        r_m_wdata  <= '0;
                        r_d_streak <= '0;
                        r_state    <= S_REQ;
                    end else if (w_grant_d) begin
                        r_owner_d <= 1'b1;
                        r_m_req   <= 1'b1;
                        r_m_we    <= bus.d_we;
                        r_m_be    <= bus.d_we ? bus.d_be : 4'b1111;
                        r_m_addr  <= bus.d_addr;
                        r_m_wdata <= bus.d_wdata;
                        r_state   <= S_REQ;
                        if (!bus.if_req)
                            r_d_streak <= '0;
                        else if (!w_streak_full)
                            r_d_streak <= r_d_streak + SW'(1);
                    end else if (!bus.if_req) begin
                        r_d_streak <= '0;
                    end
                end
                S_REQ: begin
                    if (!r_owner_d && bus.if_kill)
                        r_drop <= 1'b1;
                    if (bus.m_gnt) begin
                        r_m_req <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.m_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!r_owner_d && bus.if_kill) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.m_req   = r_m_req;
    assign bus.m_we    = r_m_we;
    assign bus.m_be    = r_m_be;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;

    // A kill arriving with the response itself must also suppress it.
    assign bus.if_rvalid = w_done && !r_owner_d && !r_drop && !bus.if_kill;
    assign bus.if_rdata  = bus.m_rdata;
    assign bus.d_rvalid  = w_done && r_owner_d;
    assign bus.d_rdata   = bus.m_rdata;

    assign busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory responder that
// grants after a programmable delay and answers a programmable time later.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    int   n_tests = 0;
    int   n_fail  = 0;

    int          gnt_delay = 0;
    int          rsp_delay = 1;
    logic [31:0] mem_rdata = '0;
    int          gcnt = 0;
    int          rcnt = 0;
    logic [31:0] glog[$];

    mem_port_arbiter_if #(.AW(32)) bus_if ();

    mem_port_arbiter #(.AW(32), .MAX_D_STREAK(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Memory model: changes its outputs on the falling edge only.
    always @(negedge clk) begin
        bus_if.m_rvalid = 1'b0;
        if (rcnt > 0) begin
            rcnt = rcnt - 1;
            if (rcnt == 0) bus_if.m_rvalid = 1'b1;
        end
        bus_if.m_rdata = mem_rdata;
        bus_if.m_gnt   = 1'b0;
        if (bus_if.m_req === 1'b1) begin
            if (gcnt >= gnt_delay) begin
                bus_if.m_gnt = 1'b1;
                gcnt = 0;
                rcnt = rsp_delay;
                glog.push_back(bus_if.m_addr);
            end else begin
                gcnt = gcnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    initial begin
        int base, nd, ni, nreq;
        bit dropped, done;
        reset_n = 1'b0;
        bus_if.if_req = 0; bus_if.if_addr = '0; bus_if.if_kill = 0;
        bus_if.d_req = 0; bus_if.d_we = 0; bus_if.d_be = '0;
        bus_if.d_addr = '0; bus_if.d_wdata = '0;
        tick();
        chk("rst_busy",   32'(busy), 0);
        chk("rst_m_req",  32'(bus_if.m_req), 0);
        chk("rst_m_we",   32'(bus_if.m_we), 0);
        chk("rst_m_be",   32'(bus_if.m_be), 0);
        chk("rst_m_addr", bus_if.m_addr, 0);
        chk("rst_m_wdat", bus_if.m_wdata, 0);
        chk("rst_if_rv",  32'(bus_if.if_rvalid), 0);
        chk("rst_d_rv",   32'(bus_if.d_rvalid), 0);
        reset_n = 1'b1;
        tick();

        // single fetch, minimum latency
        bus_if.if_req = 1; bus_if.if_addr = 32'h10; mem_rdata = 32'h93;
        tick();
        chk("t1_m_req", 32'(bus_if.m_req), 1);
        chk("t1_addr",  bus_if.m_addr, 32'h10);
        chk("t1_be",    32'(bus_if.m_be), 32'hF);
        chk("t1_busy1", 32'(busy), 1);
        tick();
        chk("t1_if_rv", 32'(bus_if.if_rvalid), 1);
        chk("t1_rdata", bus_if.if_rdata, 32'h93);
        chk("t1_busy2", 32'(busy), 1);
        chk("t1_m_req0", 32'(bus_if.m_req), 0);
        bus_if.if_req = 0;
        tick();
        chk("t1_idle", 32'(busy), 0);
        chk("t1_if_rv0", 32'(bus_if.if_rvalid), 0);

        // store and fetch together: store first
        bus_if.if_req = 1; bus_if.if_addr = 32'h20;
        bus_if.d_req = 1; bus_if.d_we = 1; bus_if.d_be = 4'b0011;
        bus_if.d_addr = 32'h100; bus_if.d_wdata = 32'hDEAD_BEEF;
        mem_rdata = 32'h13;
        tick();
        chk("t2_we",    32'(bus_if.m_we), 1);
        chk("t2_be",    32'(bus_if.m_be), 32'h3);
        chk("t2_addr",  bus_if.m_addr, 32'h100);
        chk("t2_wdata", bus_if.m_wdata, 32'hDEAD_BEEF);
        tick();
        chk("t2_d_rv",  32'(bus_if.d_rvalid), 1);
        chk("t2_if_rv", 32'(bus_if.if_rvalid), 0);
        bus_if.d_req = 0; bus_if.d_we = 0;
        tick();
        chk("t2_idle", 32'(busy), 0);
        tick();
        chk("t2_f_req",  32'(bus_if.m_req), 1);
        chk("t2_f_addr", bus_if.m_addr, 32'h20);
        chk("t2_f_we",   32'(bus_if.m_we), 0);
        tick();
        chk("t2_f_rv",   32'(bus_if.if_rvalid), 1);
        chk("t2_f_data", bus_if.if_rdata, 32'h13);
        bus_if.if_req = 0;
        tick();

        // starvation guard with MAX_D_STREAK=2
        base = glog.size(); nd = 0; ni = 0; dropped = 0; done = 0;
        bus_if.if_req = 1; bus_if.if_addr = 32'h30;
        bus_if.d_req = 1; bus_if.d_addr = 32'h200; bus_if.d_be = 4'b1111;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (bus_if.d_rvalid === 1'b1) nd++;
            if (bus_if.if_rvalid === 1'b1) ni++;
            if (!dropped && glog.size() >= base + 6) begin
                bus_if.if_req = 0; bus_if.d_req = 0; dropped = 1;
            end else if (dropped && busy === 1'b0) begin
                done = 1;
            end
        end
        chk("t3_done", 32'(done), 1);
        if (glog.size() >= base + 6) begin
            chk("t3_g0", glog[base+0], 32'h200);
            chk("t3_g1", glog[base+1], 32'h200);
            chk("t3_g2", glog[base+2], 32'h30);
            chk("t3_g3", glog[base+3], 32'h200);
            chk("t3_g4", glog[base+4], 32'h200);
            chk("t3_g5", glog[base+5], 32'h30);
        end else begin
            chk("t3_ngrants", 32'(glog.size() - base), 6);
        end
        chk("t3_nd", 32'(nd), 4);
        chk("t3_ni", 32'(ni), 2);
        chk("t3_streak", 32'(dut.r_d_streak), 0);

        // kill during WAIT, then a fresh fetch
        rsp_delay = 3;
        bus_if.if_req = 1; bus_if.if_addr = 32'h50; mem_rdata = 32'h6F;
        tick();
        chk("t4_req", 32'(bus_if.m_req), 1);
        tick();
        bus_if.if_kill = 1;
        tick();
        bus_if.if_kill = 0; bus_if.if_req = 0;
        chk("t4_rv_a", 32'(bus_if.if_rvalid), 0);
        tick();
        chk("t4_mrv",  32'(bus_if.m_rvalid), 1);
        chk("t4_rv_b", 32'(bus_if.if_rvalid), 0);
        tick();
        chk("t4_idle", 32'(busy), 0);
        rsp_delay = 1;
        bus_if.if_req = 1; bus_if.if_addr = 32'h40; mem_rdata = 32'h0000_0113;
        tick();
        chk("t4_addr", bus_if.m_addr, 32'h40);
        tick();
        chk("t4_rv_c", 32'(bus_if.if_rvalid), 1);
        chk("t4_data", bus_if.if_rdata, 32'h0000_0113);
        bus_if.if_req = 0;
        tick();

        // kill in the same cycle as the response
        bus_if.if_req = 1; bus_if.if_addr = 32'h60;
        tick();
        tick();
        bus_if.if_kill = 1;
        #1;
        chk("t4k_mrv", 32'(bus_if.m_rvalid), 1);
        chk("t4k_rv",  32'(bus_if.if_rvalid), 0);
        bus_if.if_kill = 0; bus_if.if_req = 0;
        tick();
        chk("t4k_idle", 32'(busy), 0);

        // grant backpressure on a load
        gnt_delay = 3; nreq = 0;
        bus_if.d_req = 1; bus_if.d_we = 0; bus_if.d_be = 4'b0101;
        bus_if.d_addr = 32'h300; mem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t5_req%0d", i),  32'(bus_if.m_req), 1);
            chk($sformatf("t5_addr%0d", i), bus_if.m_addr, 32'h300);
            chk($sformatf("t5_be%0d", i),   32'(bus_if.m_be), 32'hF);
        end
        tick();
        chk("t5_d_rv", 32'(bus_if.d_rvalid), 1);
        chk("t5_data", bus_if.d_rdata, 32'hCAFE_F00D);
        bus_if.d_req = 0; gnt_delay = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.m_req === 1'b1) nreq++;
        end
        chk("t5_no_req", 32'(nreq), 0);

        // reset in WAIT, late response ignored
        rsp_delay = 3;
        bus_if.if_req = 1; bus_if.if_addr = 32'h70;
        tick();
        tick();
        chk("t6_busy", 32'(busy), 1);
        reset_n = 0;
        #1;
        chk("t6_r_busy", 32'(busy), 0);
        chk("t6_r_req",  32'(bus_if.m_req), 0);
        chk("t6_r_addr", bus_if.m_addr, 0);
        chk("t6_r_be",   32'(bus_if.m_be), 0);
        bus_if.if_req = 0;
        tick();
        reset_n = 1;
        tick();
        chk("t6_mrv",   32'(bus_if.m_rvalid), 1);
        chk("t6_if_rv", 32'(bus_if.if_rvalid), 0);
        chk("t6_d_rv",  32'(bus_if.d_rvalid), 0);
        chk("t6_idle",  32'(busy), 0);
        rsp_delay = 1;
        bus_if.d_req = 1; bus_if.d_we = 0; bus_if.d_addr = 32'h400;
        mem_rdata = 32'h1234;
        tick();
        chk("t6_addr", bus_if.m_addr, 32'h400);
        tick();
        chk("t6_d_rv2", 32'(bus_if.d_rvalid), 1);
        chk("t6_data",  bus_if.d_rdata, 32'h1234);
        bus_if.d_req = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
